// File: rtl/mem_responder.sv
// mem_responder: single-port backing memory for the multicycle RV32I datapath.
// Serves one read or write at a time. Both happen at the acceptance edge and
// mem_resp pulses a fixed LATENCY cycles later. Byte lanes are masked on writes,
// and protocol and range errors are sticky until reset.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err,
  output logic        range_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Loaded into the counter on acceptance. BUSY then lasts LATENCY-1 cycles.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state, state_next;
  logic [3:0]        count, count_next;
  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       lane_mask;
  logic [31:0]       storage [2**ADDR_W];

  // Requests are only looked at in IDLE. The read or write is done at this same
  // edge, so nothing has to be carried through BUSY. That is why a request
  // dropped during BUSY still completes normally.
  assign accept    = (state == IDLE) && (mem_read || mem_write);
  assign in_range  = (mem_address >> (ADDR_W + 2)) == 32'd0;
  assign word_idx  = mem_address[ADDR_W+1:2];
  assign lane_mask = {{8{mem_byte_enable[3]}}, {8{mem_byte_enable[2]}},
                      {8{mem_byte_enable[1]}}, {8{mem_byte_enable[0]}}};

  // State and latency counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state logic and the response pulse
  always_comb begin
    state_next = state;
    count_next = count;
    mem_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            count_next = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (count <= 4'd1) begin
          state_next = RESP;
          count_next = 4'd0;
        end else begin
          count_next = count - 4'd1;
        end
      end
      RESP: begin
        mem_resp   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  // Read data capture and sticky error flags, all updated at acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rdata <= 32'd0;
      proto_err <= 1'b0;
      range_err <= 1'b0;
    end else if (accept) begin
      if (mem_read && !mem_write) begin
        mem_rdata <= in_range ? storage[word_idx] : 32'd0;
      end
      if (mem_read && mem_write) begin
        proto_err <= 1'b1;
      end
      if (!in_range) begin
        range_err <= 1'b1;
      end
    end
  end

  // Storage write with byte lanes. There is no reset here, so contents survive
  // reset. The rst gate keeps a request that is seen during reset from committing.
  always_ff @(posedge clk) begin
    if (rst && accept && mem_write && in_range) begin
      storage[word_idx] <= (storage[word_idx] & ~lane_mask) | (mem_wdata & lane_mask);
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: runs three responders (LATENCY 2, 1 and 5) against a
// transaction-level model made of a word array, a read-data register and
// sticky error flags.
module tb_mem_responder;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;

  logic [2:0]       rd, wr;
  logic [2:0][31:0] addr, wdata;
  logic [2:0][3:0]  be;
  wire  [2:0][31:0] rdata;
  wire  [2:0]       resp, perr, rerr;

  // Reference model state for each DUT
  logic [31:0] mdl [3][256];
  logic [31:0] m_rdata [3];
  logic        m_perr [3];
  logic        m_rerr [3];

  int asserts  = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(AW), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .mem_address(addr[0]), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_byte_enable(be[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
    .mem_resp(resp[0]), .proto_err(perr[0]), .range_err(rerr[0]));

  mem_responder #(.ADDR_W(AW), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_address(addr[1]), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_byte_enable(be[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
    .mem_resp(resp[1]), .proto_err(perr[1]), .range_err(rerr[1]));

  mem_responder #(.ADDR_W(AW), .LATENCY(5)) dut2 (
    .clk(clk), .rst(rst), .mem_address(addr[2]), .mem_read(rd[2]), .mem_write(wr[2]),
    .mem_byte_enable(be[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]),
    .mem_resp(resp[2]), .proto_err(perr[2]), .range_err(rerr[2]));

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check every DUT output against its reset value
  task automatic check_reset_outputs();
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("rst_resp%0d", d),  {31'd0, resp[d]}, 32'd0);
      checkOutput($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
      checkOutput($sformatf("rst_perr%0d", d),  {31'd0, perr[d]}, 32'd0);
      checkOutput($sformatf("rst_rerr%0d", d),  {31'd0, rerr[d]}, 32'd0);
    end
  endtask

  // Update the model for a request at its acceptance edge
  task automatic model_accept(input int d, input bit r, input bit w, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] wd);
    logic        inr;
    int          idx;
    logic [31:0] mask;
    inr  = (a / 32'd1024) == 0;
    idx  = int'(a % 32'd1024) / 4;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    if (w) begin
      if (r) m_perr[d] = 1'b1;
      if (inr) mdl[d][idx] = (mdl[d][idx] & ~mask) | (wd & mask);
      else     m_rerr[d] = 1'b1;
    end else if (r) begin
      m_rdata[d] = inr ? mdl[d][idx] : 32'd0;
      if (!inr) m_rerr[d] = 1'b1;
    end
  endtask

  // One full transaction, called just after a negedge while the DUT is idle.
  // The response must appear in exactly the LATENCY-th cycle, and the cycle
  // after it must be idle.
  task automatic applyStimulus(input int d, input bit r, input bit w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] wd, input bit drop_early);
    int lat;
    lat = lat_of(d);
    rd[d] = r; wr[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    model_accept(d, r, w, a, b, wd);
    @(posedge clk);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (drop_early && k == 1) begin
        rd[d] = 1'b0; wr[d] = 1'b0;
      end
      checkOutput($sformatf("resp_d%0d_k%0d", d, k), {31'd0, resp[d]}, {31'd0, k == lat});
      if (k == lat) begin
        checkOutput($sformatf("rdata_d%0d", d), rdata[d], m_rdata[d]);
        checkOutput($sformatf("perr_d%0d", d), {31'd0, perr[d]}, {31'd0, m_perr[d]});
        checkOutput($sformatf("rerr_d%0d", d), {31'd0, rerr[d]}, {31'd0, m_rerr[d]});
        rd[d] = 1'b0; wr[d] = 1'b0;
      end
    end
  endtask

  initial begin
    int          d;
    int          op;
    logic [31:0] a;
    rd = '0; wr = '0; addr = '0; wdata = '0; be = '0;
    for (int i = 0; i < 3; i++) begin
      m_rdata[i] = 32'd0; m_perr[i] = 1'b0; m_rerr[i] = 1'b0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] initialising words 0..15 of every DUT");
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 16; w++)
        applyStimulus(i, 1'b0, 1'b1, 32'(w * 4), 4'hF, $urandom, 1'b0);

    $display("[TB] full write/read and byte lanes");
    applyStimulus(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    checkOutput("full_rw", rdata[0], 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 1'b1, 32'h10, 4'b0010, 32'h00001200, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    checkOutput("byte_lane", rdata[0], 32'hDEAD12EF);
    applyStimulus(0, 1'b0, 1'b1, 32'h10, 4'b0000, 32'h12345678, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    checkOutput("be_none", rdata[0], 32'hDEAD12EF);

    $display("[TB] latency sweep");
    for (int i = 1; i < 3; i++) begin
      applyStimulus(i, 1'b0, 1'b1, 32'h8, 4'hF, 32'hCAFEF00D, 1'b0);
      applyStimulus(i, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0);
      checkOutput($sformatf("lat_rd%0d", i), rdata[i], 32'hCAFEF00D);
    end

    $display("[TB] dropped requests");
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1);
    checkOutput("drop_rd0", rdata[0], 32'hDEAD12EF);
    applyStimulus(2, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1);
    checkOutput("drop_rd2", rdata[2], 32'hCAFEF00D);

    $display("[TB] error cases");
    applyStimulus(0, 1'b1, 1'b0, 32'h400, 4'h0, 32'h0, 1'b0);
    checkOutput("range_rdata", rdata[0], 32'd0);
    checkOutput("range_flag", {31'd0, rerr[0]}, 32'd1);
    applyStimulus(0, 1'b1, 1'b1, 32'h4, 4'hF, 32'h55, 1'b0);
    checkOutput("proto_flag", {31'd0, perr[0]}, 32'd1);
    checkOutput("proto_rdata", rdata[0], 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b0);
    checkOutput("proto_wrote", rdata[0], 32'h55);

    $display("[TB] random traffic");
    for (int n = 0; n < 80; n++) begin
      d  = $urandom_range(0, 2);
      op = $urandom_range(0, 5);
      a  = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(10, 31));
      applyStimulus(d, op <= 2 || op == 5, op >= 3, a, 4'($urandom), $urandom,
                    $urandom_range(0, 3) == 0);
    end

    $display("[TB] reset in the middle of a write");
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h10; be[0] = 4'hF; wdata[0] = 32'hA5A50F0F;
    model_accept(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hA5A50F0F);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      m_rdata[i] = 32'd0; m_perr[i] = 1'b0; m_rerr[i] = 1'b0;
    end
    check_reset_outputs();
    wr[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("post_rst_idle", {31'd0, resp[0]}, 32'd0);
    end
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    checkOutput("rst_kept_write", rdata[0], 32'hA5A50F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Single-port memory responder for the multicycle RV32I datapath. It is the far end of the mem_read / mem_write / mem_byte_enable / mem_resp interface that the control FSM initiates.
- It accepts one request at a time, applies byte-lane write enables, and returns read data with a fixed, parameterised latency.
- Used as the simulation/FPGA backing memory behind the datapath's MAR, MDR and data_out registers.

Parameters:
- ADDR_W, 8: word-index width; storage holds 2**ADDR_W 32-bit words.
- LATENCY, 2: cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- mem_address  input  32  byte address; bits [1:0] are ignored.
- mem_read  input  1  read request; held high by the initiator until mem_resp.
- mem_write  input  1  write request; held high by the initiator until mem_resp.
- mem_byte_enable  input  4  write lane mask; bit i enables byte i (bits [8i+7:8i]).
- mem_wdata  input  32  write data.
- mem_rdata  output  32  read data; valid in the mem_resp cycle of a read.
- mem_resp  output  1  one-cycle completion pulse.
- proto_err  output  1  sticky: mem_read and mem_write were seen high together at acceptance.
- range_err  output  1  sticky: an accepted address had a nonzero bit in [31:ADDR_W+2].

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; counter is 0.
  - mem_resp, mem_rdata, proto_err and range_err are all 0.
  - Storage array is NOT cleared.
  - Reset mid-operation abandons the transaction. A pending write that was already committed stays committed.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If mem_read or mem_write is high at a rising edge, that edge is the acceptance edge.
  - At acceptance, latch the op, word index = mem_address[ADDR_W+1:2], mem_byte_enable and mem_wdata.
  - Next state is RESP if LATENCY == 1; otherwise BUSY with counter = LATENCY-1.
- BUSY: decrement counter each cycle; move to RESP when counter reaches 1.
- RESP:
  - mem_resp = 1 for exactly one cycle; next state is IDLE.
  - Requests are never sampled in RESP. The initiator drops its request in the cycle after RESP.
- Request timing: a request accepted at edge N gives mem_resp high in cycle N+LATENCY.
- Turnaround: the earliest next acceptance is the edge ending the IDLE cycle that follows RESP. There is always at least one idle cycle between transactions.
- Write:
  - Commit happens at the acceptance edge, only for lanes with byte_enable=1; other lanes are unchanged.
  - byte_enable = 0000 is a legal no-op write and still responds.
- Read:
  - mem_rdata is loaded from the array at the acceptance edge.
  - It is held until the next accepted read; writes do not change mem_rdata.
  - Read-after-write returns the new data because transactions are serialised.
- Simultaneous mem_read and mem_write at acceptance: treat as a write (no mem_rdata update) and set proto_err.
- Out-of-range address: reads load 0 into mem_rdata, writes are dropped, range_err is set, and the response is still issued with normal latency.
- Initiator drops its request during BUSY: the transaction completes anyway using the latched values, and mem_resp still pulses.
- Requests not held through acceptance are not remembered. Only the level at IDLE edges matters.
- Sticky errors clear only on reset.

Test Plan:
- Reset with LATENCY=2: assert rst low mid-BUSY -> mem_resp=0, mem_rdata=0, both errors 0, FSM IDLE; the next read of a previously written word returns its value.
- Full write then read: write 0xDEADBEEF to 0x00000010 with be=1111, then read 0x00000010 -> mem_resp exactly 2 cycles after each acceptance; mem_rdata=0xDEADBEEF in the read's resp cycle.
- Byte lanes: word 0x10=0xDEADBEEF; write 0x00001200 with be=0010; read back -> 0xDEAD12EF. Write be=0000, read -> unchanged.
- Latency sweep LATENCY=1 and LATENCY=5, with mem_read held until resp -> resp in cycle N+1 and N+5 respectively, one cycle wide, followed by at least one idle cycle before the next resp.
- Errors (ADDR_W=8):
  - Read 0x00000400 -> mem_rdata=0, range_err=1, resp still issued.
  - Then mem_read=mem_write=1 to 0x4 with wdata 0x55 -> word 1 becomes 0x55, proto_err=1, mem_rdata still 0.
- Dropped request: accept a read of 0x10, deassert mem_read in BUSY -> mem_resp still pulses at N+LATENCY with the correct data.
